// File: rtl/l2_flush_ctrl.sv
// l2_flush_ctrl: sequences a full L2 flush.
// Walks every set/way in order (set-major, way-minor). Each line is read, then
// written back if valid and dirty, then invalidated if valid. After the last
// line it waits for all outstanding requests to retire before signalling done.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   flush_req         start pulse, honoured only while idle
//   ongoing_atomic    holds off the walk while high
//   free_reqs         free request-tracking entries (N_REQS = none outstanding)
//   rd_en             tag/state read strobe
//   rd_set, rd_way    line index for read, writeback and invalidate
//   line_valid/dirty  state of the line read, one cycle after rd_en
//   wb_valid/wb_ready writeback request handshake
//   inv_en            one-cycle invalidate strobe
//   flush_busy        high whenever not idle
//   flush_done        one-cycle completion pulse
//   wb_cnt            writebacks issued by the current/last flush, saturating
module l2_flush_ctrl #(
    parameter int unsigned L2_SETS      = 256,
    parameter int unsigned L2_WAYS      = 8,
    parameter int unsigned SET_BITS     = 8,
    parameter int unsigned WAY_BITS     = 3,
    parameter int unsigned N_REQS       = 4,
    parameter int unsigned REQS_BITS_P1 = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_req,
    input  logic                    ongoing_atomic,
    input  logic [REQS_BITS_P1-1:0] free_reqs,
    output logic                    rd_en,
    output logic [SET_BITS-1:0]     rd_set,
    output logic [WAY_BITS-1:0]     rd_way,
    input  logic                    line_valid,
    input  logic                    line_dirty,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic                    inv_en,
    output logic                    flush_busy,
    output logic                    flush_done,
    output logic [15:0]             wb_cnt
);

    localparam int unsigned CNT_BITS = 16;

    localparam logic [SET_BITS-1:0]     LAST_SET = SET_BITS'(L2_SETS - 1);
    localparam logic [WAY_BITS-1:0]     LAST_WAY = WAY_BITS'(L2_WAYS - 1);
    localparam logic [REQS_BITS_P1-1:0] ALL_FREE = REQS_BITS_P1'(N_REQS);
    localparam logic [CNT_BITS-1:0]     CNT_MAX  = {CNT_BITS{1'b1}};

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_CHECK,
        S_ISSUE,
        S_INV,
        S_NEXT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [SET_BITS-1:0]   set_n;
    logic [WAY_BITS-1:0]   way_n;
    logic [CNT_BITS-1:0]   cnt_n;
    logic                  rd_en_n;
    logic                  wb_valid_n;
    logic                  inv_en_n;
    logic                  busy_n;
    logic                  done_n;
    logic                  wb_fire;
    logic                  last_line;

    assign wb_fire   = wb_valid && wb_ready;
    assign last_line = (rd_set == LAST_SET) && (rd_way == LAST_WAY);

    // Next-state, counter and next-output decode.
    always_comb begin
        state_n = state;
        set_n   = rd_set;
        way_n   = rd_way;
        cnt_n   = wb_cnt;

        unique case (state)
            S_IDLE: begin
                if (flush_req) begin
                    state_n = S_WAIT;
                    set_n   = '0;
                    way_n   = '0;
                    cnt_n   = '0;
                end
            end
            S_WAIT: begin
                if (!ongoing_atomic) begin
                    state_n = S_READ;
                end
            end
            S_READ: begin
                state_n = S_CHECK;
            end
            S_CHECK: begin
                // line_dirty is meaningless for an invalid line
                if (line_valid && line_dirty) begin
                    state_n = S_ISSUE;
                end else if (line_valid) begin
                    state_n = S_INV;
                end else begin
                    state_n = S_NEXT;
                end
            end
            S_ISSUE: begin
                if (wb_fire) begin
                    state_n = S_INV;
                    if (wb_cnt != CNT_MAX) begin
                        cnt_n = wb_cnt + CNT_BITS'(1);
                    end
                end
            end
            S_INV: begin
                state_n = S_NEXT;
            end
            S_NEXT: begin
                // The final line leaves the indices in place
                if (last_line) begin
                    state_n = S_DRAIN;
                end else begin
                    state_n = S_READ;
                    if (rd_way != LAST_WAY) begin
                        way_n = rd_way + WAY_BITS'(1);
                    end else begin
                        way_n = '0;
                        set_n = rd_set + SET_BITS'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (free_reqs == ALL_FREE) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        rd_en_n  = (state_n == S_READ);
        inv_en_n = (state_n == S_INV);
        busy_n   = (state_n != S_IDLE);
        done_n   = (state_n == S_DONE);
        // A raised request stays up until accepted; it is only raised with a
        // free tracking entry available.
        wb_valid_n = (state_n == S_ISSUE) && (wb_valid || (free_reqs != '0));
    end

    // State, index counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rd_set     <= '0;
            rd_way     <= '0;
            wb_cnt     <= '0;
            rd_en      <= 1'b0;
            wb_valid   <= 1'b0;
            inv_en     <= 1'b0;
            flush_busy <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_n;
            rd_set     <= set_n;
            rd_way     <= way_n;
            wb_cnt     <= cnt_n;
            rd_en      <= rd_en_n;
            wb_valid   <= wb_valid_n;
            inv_en     <= inv_en_n;
            flush_busy <= busy_n;
            flush_done <= done_n;
        end
    end

    // Array strobes never overlap.
    a_strobes_exclusive : assert property (
        @(posedge clk) disable iff (rst) $onehot0({rd_en, wb_valid, inv_en})
    );

endmodule

// File: tb/tb_l2_flush_ctrl.sv
// tb_l2_flush_ctrl: directed bench for l2_flush_ctrl (4 sets x 2 ways).
// A transaction-level model expands each accepted flush into the ordered list
// of array operations it must produce; a compare process matches every strobe
// and handshake against that list each cycle and checks the cycle-level rules.
// Hand-computed latencies and counts pin the individual scenarios.
module tb_l2_flush_ctrl;

    localparam int N_LINES = 8;
    localparam int N_REQS  = 4;
    localparam int OP_RD   = 0;
    localparam int OP_WB   = 1;
    localparam int OP_INV  = 2;

    typedef struct {
        int kind;
        int idx;
    } op_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_req;
    logic        ongoing_atomic;
    logic [2:0]  free_reqs;
    logic        rd_en;
    logic [1:0]  rd_set;
    logic [0:0]  rd_way;
    logic        line_valid;
    logic        line_dirty;
    logic        wb_valid;
    logic        wb_ready;
    logic        inv_en;
    logic        flush_busy;
    logic        flush_done;
    logic [15:0] wb_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    bit mem_v [N_LINES];
    bit mem_d [N_LINES];

    // Model state, owned by the compare process
    op_t        ops[$];
    bit         model_busy  = 1'b0;
    int         wb_model    = 0;
    int         req_cyc     = 0;
    int         done_cyc    = 0;
    int         done_events = 0;
    int         rd_cnt      = 0;
    int         inv_cnt     = 0;
    int         wb_hs       = 0;
    int         first_rd_cyc = 0;
    int         wb_rise_cyc = 0;
    int         hold_cnt    = 0;
    int         wb_hold_len = 0;
    int         wb_idx_last = -1;
    bit         prev_wbv    = 1'b0;
    bit         prev_wbr    = 1'b0;
    logic [2:0] prev_free   = 3'd4;
    int         prev_idx    = 0;

    l2_flush_ctrl #(
        .L2_SETS      (4),
        .L2_WAYS      (2),
        .SET_BITS     (2),
        .WAY_BITS     (1),
        .N_REQS       (4),
        .REQS_BITS_P1 (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_req      (flush_req),
        .ongoing_atomic (ongoing_atomic),
        .free_reqs      (free_reqs),
        .rd_en          (rd_en),
        .rd_set         (rd_set),
        .rd_way         (rd_way),
        .line_valid     (line_valid),
        .line_dirty     (line_dirty),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .inv_en         (inv_en),
        .flush_busy     (flush_busy),
        .flush_done     (flush_done),
        .wb_cnt         (wb_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mem(input logic [7:0] v, input logic [7:0] d);
        for (int i = 0; i < N_LINES; i++) begin
            mem_v[i] = v[i];
            mem_d[i] = d[i];
        end
    endtask

    function automatic op_t mk_op(input int kind, input int idx);
        op_t o;
        o.kind = kind;
        o.idx  = idx;
        return o;
    endfunction

    // Tag array: returns the addressed line state in the cycle after rd_en.
    initial begin : line_env
        bit pend;
        int pidx;
        line_valid = 1'b0;
        line_dirty = 1'b0;
        forever begin
            @(negedge clk);
            pend = rd_en;
            pidx = int'({rd_set, rd_way});
            @(posedge clk);
            #1;
            line_valid = pend && mem_v[pidx];
            line_dirty = pend && mem_d[pidx];
        end
    end

    task automatic compare_cycle();
        int idx;
        int front_kind;
        bit busy_start;
        idx        = int'({rd_set, rd_way});
        busy_start = model_busy;
        front_kind = (ops.size() > 0) ? ops[0].kind : -1;

        chk("busy", int'(flush_busy), int'(model_busy));
        chk("wb_cnt", int'(wb_cnt), wb_model);
        chk("strobe_excl", int'($countones({rd_en, wb_valid, inv_en}) <= 1), 1);

        if (rd_en) begin
            chk("rd_kind", front_kind, OP_RD);
            if (front_kind == OP_RD) begin
                chk("rd_idx", idx, ops[0].idx);
                void'(ops.pop_front());
            end
            if (rd_cnt == 0) first_rd_cyc = cyc;
            rd_cnt++;
        end

        if (inv_en) begin
            chk("inv_kind", front_kind, OP_INV);
            if (front_kind == OP_INV) begin
                chk("inv_idx", idx, ops[0].idx);
                void'(ops.pop_front());
            end
            inv_cnt++;
        end

        if (wb_valid) begin
            chk("wb_kind", front_kind, OP_WB);
            if (prev_wbv && !prev_wbr) begin
                chk("wb_idx_stable", idx, prev_idx);
            end else begin
                chk("wb_rise_free", int'(prev_free != 3'd0), 1);
                wb_rise_cyc = cyc;
                hold_cnt    = 0;
            end
            hold_cnt++;
            if (wb_ready) begin
                if (front_kind == OP_WB) begin
                    chk("wb_idx", idx, ops[0].idx);
                    void'(ops.pop_front());
                end
                wb_hold_len = hold_cnt;
                wb_idx_last = idx;
                wb_hs++;
                if (wb_model < 65535) wb_model++;
            end
        end else if (prev_wbv && !prev_wbr) begin
            chk("wb_dropped", int'(wb_valid), 1);
        end

        if (flush_done) begin
            chk("done_when_busy", int'(model_busy), 1);
            chk("done_ops_left", ops.size(), 0);
            chk("done_after_drain", int'(prev_free), N_REQS);
            done_cyc = cyc;
            done_events++;
            model_busy = 1'b0;
        end

        // Accept: expand the flush into its ordered operation list
        if (flush_req && !busy_start && !rst) begin
            model_busy = 1'b1;
            req_cyc    = cyc;
            wb_model   = 0;
            rd_cnt     = 0;
            inv_cnt    = 0;
            wb_hs      = 0;
            ops.delete();
            for (int i = 0; i < N_LINES; i++) begin
                ops.push_back(mk_op(OP_RD, i));
                if (mem_v[i] && mem_d[i]) ops.push_back(mk_op(OP_WB, i));
                if (mem_v[i]) ops.push_back(mk_op(OP_INV, i));
            end
        end

        prev_wbv  = wb_valid;
        prev_wbr  = wb_ready;
        prev_free = free_reqs;
        prev_idx  = idx;

        if (rst) begin
            model_busy = 1'b0;
            wb_model   = 0;
            ops.delete();
            prev_wbv   = 1'b0;
            prev_wbr   = 1'b0;
        end
    endtask

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) compare_cycle();
        end
    end

    // Inputs for cycle k of scenario t; k = 0 is the request cycle.
    task automatic drive(input int t, input int k);
        flush_req      = (k == 0);
        ongoing_atomic = 1'b0;
        free_reqs      = 3'd4;
        wb_ready       = 1'b1;
        rst            = 1'b0;
        case (t)
            3: begin
                free_reqs = (k < 6) ? 3'd0 : ((k < 13) ? 3'd1 : 3'd4);
                wb_ready  = (k >= 12);
            end
            4: begin
                ongoing_atomic = (k >= 0 && k <= 9);
                if (k == 20) flush_req = 1'b1;
            end
            5: free_reqs = (k >= 26 && k <= 32) ? 3'd3 : 3'd4;
            6: begin
                wb_ready = 1'b0;
                rst      = (k == 12);
            end
            default: ;
        endcase
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_rd_en"},      int'(rd_en),      0);
        chk({pfx, "_wb_valid"},   int'(wb_valid),   0);
        chk({pfx, "_inv_en"},     int'(inv_en),     0);
        chk({pfx, "_flush_busy"}, int'(flush_busy), 0);
        chk({pfx, "_flush_done"}, int'(flush_done), 0);
        chk({pfx, "_wb_cnt"},     int'(wb_cnt),     0);
        chk({pfx, "_rd_set"},     int'(rd_set),     0);
        chk({pfx, "_rd_way"},     int'(rd_way),     0);
    endtask

    // exp_lat < 0: no completion expected within max_k cycles
    task automatic run_flush(input int t, input int max_k, input int exp_lat, input int exp_cnt);
        int d0;
        d0 = done_events;
        for (int k = 0; k <= max_k && done_events == d0; k++) begin
            if (t == 6 && k == 13) check_all_zero("rst_mid");
            drive(t, k);
            if (t == 6 && k == 12) chk("pre_rst_wb_valid", int'(wb_valid), 1);
            tick();
        end
        if (exp_lat >= 0) begin
            chk($sformatf("t%0d_done_seen", t), done_events - d0, 1);
            chk($sformatf("t%0d_latency", t), done_cyc - req_cyc, exp_lat);
            chk($sformatf("t%0d_wb_cnt", t), int'(wb_cnt), exp_cnt);
        end else begin
            chk($sformatf("t%0d_no_done", t), done_events - d0, 0);
        end
        drive(0, -1);
        repeat (4) tick();
    endtask

    initial begin : main
        rst            = 1'b1;
        flush_req      = 1'b0;
        ongoing_atomic = 1'b0;
        free_reqs      = 3'd4;
        wb_ready       = 1'b1;
        set_mem(8'h00, 8'h00);
        tick();
        tick();
        check_all_zero("reset");
        rst    = 1'b0;
        chk_en = 1'b1;
        tick();

        // All invalid (one stale dirty bit on an invalid line)
        set_mem(8'h00, 8'h08);
        run_flush(1, 80, 27, 0);
        chk("t1_reads", rd_cnt, 8);
        chk("t1_invs", inv_cnt, 0);
        chk("t1_wbs", wb_hs, 0);

        // All valid, set 2 way 1 dirty
        set_mem(8'hFF, 8'h20);
        run_flush(2, 80, 36, 1);
        chk("t2_wb_idx", wb_idx_last, 5);
        chk("t2_invs", inv_cnt, 8);
        chk("t2_wbs", wb_hs, 1);

        // Dirty line 0: no free entry at first, then wb_ready stalled 5 cycles
        set_mem(8'h01, 8'h01);
        run_flush(3, 80, 37, 1);
        chk("t3_wb_rise", wb_rise_cyc - req_cyc, 7);
        chk("t3_wb_hold", wb_hold_len, 6);
        chk("t3_wbs", wb_hs, 1);

        // Atomic in flight for 10 cycles; second request while busy
        set_mem(8'h00, 8'h00);
        run_flush(4, 80, 36, 0);
        chk("t4_first_rd", first_rd_cyc - req_cyc, 11);
        chk("t4_reads", rd_cnt, 8);

        // Last line dirty, outstanding request retires late
        set_mem(8'h80, 8'h80);
        run_flush(5, 80, 34, 1);
        chk("t5_wb_idx", wb_idx_last, 7);

        // Reset while a writeback is pending, then a fresh flush
        set_mem(8'h04, 8'h04);
        run_flush(6, 20, -1, 0);
        run_flush(0, 80, 29, 1);
        chk("t6_wb_idx", wb_idx_last, 2);
        chk("t6_reads", rd_cnt, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
